uart_tx_arbiter: RTL and testbench

- Shares one uart_tx byte channel among NumReq byte-stream requesters, e.g. console, debug monitor and CPU MMIO.
- Arbitration is round-robin at message granularity. A winner keeps the transmitter until it presents a byte flagged last, so messages never interleave on the line.
- Sits between the requesters and uart_tx's data_in / data_in_valid / ready handshake.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_tx_arbiter_rr_pick.sv | 21 ++
 rtl/uart_tx_arbiter.sv | 88 ++++++++
 tb/tb_uart_tx_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: byte type, arbiter state encoding and round-robin pointer helper
package uart_pkg;
  typedef logic [7:0] uart_byte_t;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
  function automatic int rr_next(input int g, input int n);
    return (g + 1) % n;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first set request at or above i_rr_ptr with wrap-around
module rr_pick #(
  parameter int NumReq = 4,
  parameter int IdW    = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] i_req,
  input  logic [IdW-1:0]    i_rr_ptr,
  output logic [IdW-1:0]    o_winner,
  output logic              o_any
);
  logic [IdW-1:0] w_idx;
  always_comb begin
    o_winner = '0;
    w_idx    = '0;
    o_any    = |i_req;
    for (int i = NumReq - 1; i >= 0; i--) begin
      w_idx = IdW'((int'(i_rr_ptr) + i) % NumReq);
      o_winner = i_req[w_idx] ? w_idx : o_winner;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin sharing of one uart_tx; UART_ARB_TIMEOUT_EN adds forced release of a stalled lock
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NumReq        = 4,
  parameter int IdW           = $clog2(NumReq),
  parameter int TimeoutCycles = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NumReq-1:0]     req_valid,
  input  logic [NumReq*8-1:0]   req_data,
  input  logic [NumReq-1:0]     req_last,
  output logic [NumReq-1:0]     req_ready,
  output uart_byte_t            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [IdW-1:0]        grant_id,
  output logic                  busy,
  output logic                  timeout
);
  arb_state_t     r_state;
  logic [IdW-1:0] r_grant;
  logic [IdW-1:0] r_rr_ptr;
  logic [IdW-1:0] w_winner;
  logic           w_any;
  logic           w_locked;
  logic           w_xfer;
  logic           w_done;
  logic           w_expire;
  logic           w_release;

  rr_pick #(.NumReq(NumReq), .IdW(IdW)) u_pick (
    .i_req    (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_locked  = r_state == ARB_LOCKED;
  assign tx_valid  = w_locked && req_valid[r_grant];
  assign tx_data   = w_locked ? req_data[{r_grant, 3'b000} +: 8] : '0;
  assign req_ready = w_locked && tx_ready ? NumReq'(1) << r_grant : '0;
  assign w_xfer    = tx_valid && tx_ready;
  assign w_done    = w_xfer && req_last[r_grant];
  assign w_release = w_done || w_expire;
  assign busy      = w_locked;
  assign grant_id  = r_grant;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] r_idle_cnt;
  logic            r_timeout;
  assign w_expire = w_locked && !req_valid[r_grant] && r_idle_cnt == CntW'(TimeoutCycles - 1);
  assign timeout  = r_timeout;
  // counter sits at zero while idle, so every new lock starts a fresh count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout  <= w_expire;
      r_idle_cnt <= !w_locked || w_xfer || w_expire ? '0 :
                    !req_valid[r_grant] ? r_idle_cnt + CntW'(1) : r_idle_cnt;
    end
  end
`else
  assign w_expire = 1'b0;
  // lock never expires in this build; the comparison is constant false
  assign timeout  = TimeoutCycles < 0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ARB_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else if (!w_locked) begin
      if (w_any) begin
        r_state <= ARB_LOCKED;
        r_grant <= w_winner;
      end
    end else if (w_release) begin
      r_state  <= ARB_IDLE;
      r_rr_ptr <= IdW'(rr_next(int'(r_grant), NumReq));
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: cycle model of the arbiter rules plus directed message scenarios
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int TO = 16;
`ifdef UART_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready = 1'b0;
  logic [IW-1:0]   grant_id;
  logic            busy;
  logic            timeout;

  uart_tx_arbiter #(.NumReq(NR), .IdW(IW), .TimeoutCycles(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [8:0]    src_mem [NR][32];
  int            src_wr [NR];
  int            src_rd [NR];
  logic [NR-1:0] cap = '0;

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = src_rd[i] != src_wr[i];
      {req_last[i], req_data[8*i +: 8]} = req_valid[i] ? src_mem[i][src_rd[i]] : 9'h0;
    end
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic l);
    src_mem[r][src_wr[r]] = {l, b};
    src_wr[r]++;
    drive();
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (src_rd[i] != src_wr[i]) return 1'b1;
    return 1'b0;
  endfunction

  // spec-level model: owner, pointer, idle count, pulse
  bit        m_locked = 0;
  int        m_g = 0;
  int        m_ptr = 0;
  int        m_cnt = 0;
  bit        m_to = 0;
  bit        found;
  int        dlog [$];
  int        exp_q [$];
  int        to_pulses = 0;
  logic [7:0] exp_d;

  always @(negedge clk) begin
    chk("busy", busy, m_locked);
    chk("tx_valid", tx_valid, m_locked && req_valid[m_g]);
    chk("req_ready", req_ready, (m_locked && tx_ready) ? (1 << m_g) : 0);
    chk("timeout", timeout, m_to);
    if (m_locked) begin
      exp_d = req_data[8*m_g +: 8];
      chk("grant_id", grant_id, m_g);
      chk("tx_data", tx_data, exp_d);
    end
    cap = req_valid & req_ready;
    if (tx_valid && tx_ready) dlog.push_back(int'(grant_id) * 256 + int'(tx_data));
    if (timeout) to_pulses++;
    if (rst) begin
      m_locked = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (!m_locked) begin
        found = 0;
        for (int k = 0; k < NR; k++)
          if (!found && req_valid[(m_ptr + k) % NR]) begin
            m_g = (m_ptr + k) % NR;
            found = 1;
          end
        if (found) begin m_locked = 1; m_cnt = 0; end
      end else if (req_valid[m_g] && tx_ready) begin
        m_cnt = 0;
        if (req_last[m_g]) begin m_locked = 0; m_ptr = (m_g + 1) % NR; end
      end else if (!req_valid[m_g] && TO_EN) begin
        m_cnt++;
        if (m_cnt == TO) begin m_locked = 0; m_ptr = (m_g + 1) % NR; m_to = 1; m_cnt = 0; end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (cap[i]) src_rd[i]++;
      drive();
    end
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while ((m_locked || pending()) && n < max) begin
      cyc(1);
      n++;
    end
    chk({name, "_finished"}, n < max, 1);
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, dlog.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) chk(name, dlog[k], exp_q[k]);
  endtask

  int exp3 [12] = '{3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2};

  initial begin
    for (int i = 0; i < NR; i++) begin src_wr[i] = 0; src_rd[i] = 0; end
    cyc(3);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_ptr", dut.r_rr_ptr, 0);
    rst = 1'b0;
    tx_ready = 1'b1;
    // "Hi\n" from requester 0
    dlog.delete();
    push(0, 8'h48, 0); push(0, 8'h69, 0); push(0, 8'h0A, 1);
    wait_done("hi", 50);
    exp_q = '{'h048, 'h069, 'h00A};
    check_log("hi_log");
    chk("hi_ptr", dut.r_rr_ptr, 1);
    // two competing 3-byte messages
    dlog.delete();
    push(1, 8'h11, 0); push(1, 8'h12, 0); push(1, 8'h13, 1);
    push(2, 8'h21, 0); push(2, 8'h22, 0); push(2, 8'h23, 1);
    wait_done("pair", 60);
    exp_q = '{'h111, 'h112, 'h113, 'h221, 'h222, 'h223};
    check_log("pair_log");
    chk("pair_ptr", dut.r_rr_ptr, 3);
    chk("pair_model_ptr", m_ptr, 3);
    // all requesters streaming single-byte messages
    dlog.delete();
    for (int rep = 0; rep < 3; rep++)
      for (int r = 0; r < NR; r++) push(r, 8'h30 + 8'(r), 1);
    wait_done("rr", 100);
    chk("rr_len", dlog.size(), 12);
    for (int k = 0; k < 12; k++) begin
      chk("rr_grant", dlog[k] >> 8, exp3[k]);
      chk("rr_data", dlog[k] & 'hff, 'h30 + exp3[k]);
    end
    // long tx stall while locked
    dlog.delete();
    tx_ready = 1'b0;
    push(1, 8'hA5, 0); push(1, 8'h5A, 1);
    cyc(22);
    chk("stall_busy", busy, 1);
    chk("stall_valid", tx_valid, 1);
    chk("stall_data", tx_data, 'hA5);
    chk("stall_ready", req_ready, 0);
    chk("stall_nolog", dlog.size(), 0);
    tx_ready = 1'b1;
    wait_done("stall", 40);
    exp_q = '{'h1A5, 'h15A};
    check_log("stall_log");
    // reset in the middle of a message from requester 3
    dlog.delete();
    push(3, 8'hC1, 0); push(3, 8'hC2, 0); push(3, 8'hC3, 1);
    cyc(2);
    rst = 1'b1;
    tx_ready = 1'b0;
    src_rd[3] = src_wr[3];
    drive();
    cyc(1);
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", tx_valid, 0);
    chk("mrst_ptr", dut.r_rr_ptr, 0);
    tx_ready = 1'b1;
    push(3, 8'hD1, 1);
    wait_done("mrst", 40);
    exp_q = '{'h3C1, 'h3D1};
    check_log("mrst_log");
    // requester 0 stalls mid-message with requester 1 waiting
    dlog.delete();
    to_pulses = 0;
    push(0, 8'hE0, 0); push(1, 8'hE1, 1);
`ifdef UART_ARB_TIMEOUT_EN
    wait_done("to", 100);
    chk("to_pulses", to_pulses, 1);
    exp_q = '{'h0E0, 'h1E1};
`else
    cyc(40);
    chk("hold_busy", busy, 1);
    chk("hold_grant", grant_id, 0);
    chk("hold_pulses", to_pulses, 0);
    push(0, 8'hEF, 1);
    wait_done("hold", 40);
    exp_q = '{'h0E0, 'h0EF, 'h1E1};
`endif
    check_log("stuck_log");
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
